// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand loader: word width, loader FSM
// state encodings and the ALU operation codes driven on ALU_OP.
package alu_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        S_A   = 2'b00,
        S_B   = 2'b01,
        S_OP  = 2'b10,
        S_RUN = 2'b11
    } state_t;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOR = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_SHL = 3'b111;

endpackage

// File: rtl/alu_operand_loader.sv
// Loads two 32-bit ALU operands and an opcode from switch-sized chunks.
// Optional result capture (Fq/ZFq/OFq) is compiled in by LOADER_RESULT_CAPTURE_EN.
module alu_operand_loader
    import alu_pkg::*;
#(
    parameter int DIN_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DIN_W-1:0]  Din,
    input  logic              Load,
    input  logic              Clear,
    input  logic [WORD_W-1:0] F,
    input  logic              ZF,
    input  logic              OF,
    output logic [WORD_W-1:0] AA,
    output logic [WORD_W-1:0] BB,
    output logic [2:0]        ALU_OP,
    output logic              Valid,
    output logic [1:0]        State,
    output logic [WORD_W-1:0] Fq,
    output logic              ZFq,
    output logic              OFq
);

    localparam int CHUNKS = WORD_W / DIN_W;
    localparam int IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHUNKS - 1);

    // Handshake: Load is a one-cycle accept strobe with no back-pressure;
    // Valid is high exactly while AA/BB/ALU_OP hold a complete operation.
    state_t            state_q, state_d;
    logic [WORD_W-1:0] aa_q, aa_d;
    logic [WORD_W-1:0] bb_q, bb_d;
    logic [2:0]        op_q, op_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              cap_pend_q, cap_pend_d;
    logic [WORD_W-1:0] din_ext;
    logic              idx_last;

    assign din_ext  = WORD_W'(Din);
    assign idx_last = (idx_q == IDX_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_A;
            aa_q       <= '0;
            bb_q       <= '0;
            op_q       <= '0;
            idx_q      <= '0;
            cap_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            aa_q       <= aa_d;
            bb_q       <= bb_d;
            op_q       <= op_d;
            idx_q      <= idx_d;
            cap_pend_q <= cap_pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        aa_d       = aa_q;
        bb_d       = bb_q;
        op_d       = op_q;
        idx_d      = idx_q;
        cap_pend_d = 1'b0;
        if (Clear) begin
            state_d = S_A;
            aa_d    = '0;
            bb_d    = '0;
            op_d    = '0;
            idx_d   = '0;
        end else if (Load) begin
            unique case (state_q)
                S_A: begin
                    aa_d = (aa_q << DIN_W) | din_ext;
                    if (idx_last) begin
                        idx_d   = '0;
                        state_d = S_B;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                S_B: begin
                    bb_d = (bb_q << DIN_W) | din_ext;
                    if (idx_last) begin
                        idx_d   = '0;
                        state_d = S_OP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                S_OP: begin
                    op_d       = Din[2:0];
                    state_d    = S_RUN;
                    cap_pend_d = 1'b1;
                end
                S_RUN: begin
                    // Restart entry; Din is not consumed and ALU_OP is kept.
                    aa_d    = '0;
                    bb_d    = '0;
                    idx_d   = '0;
                    state_d = S_A;
                end
                default: state_d = S_A;
            endcase
        end
    end

    assign AA     = aa_q;
    assign BB     = bb_q;
    assign ALU_OP = op_q;
    assign Valid  = (state_q == S_RUN);
    assign State  = state_q;

`ifdef LOADER_RESULT_CAPTURE_EN
    logic [WORD_W-1:0] fq_q;
    logic              zfq_q;
    logic              ofq_q;

    // The ALU result is sampled one edge after S_RUN is entered.
    always_ff @(posedge CLK) begin
        if (RST || Clear) begin
            fq_q  <= '0;
            zfq_q <= 1'b0;
            ofq_q <= 1'b0;
        end else if (cap_pend_q) begin
            fq_q  <= F;
            zfq_q <= ZF;
            ofq_q <= OF;
        end
    end

    assign Fq  = fq_q;
    assign ZFq = zfq_q;
    assign OFq = ofq_q;
`else
    logic unused_capture;
    assign unused_capture = ^{F, ZF, OF, cap_pend_q};

    assign Fq  = '0;
    assign ZFq = 1'b0;
    assign OFq = 1'b0;
`endif

endmodule

// File: doc/alu_operand_loader.md
ALU_OPERAND_LOADER -- requirements
Module: alu_operand_loader

Interface
REQ-001 SHALL have parameter DIN_W, default 8, width of the switch data bus; legal values 8, 16, 32.
REQ-002 SHALL have port CLK  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-004 SHALL have port Din  input  DIN_W  operand/opcode chunk from board switches.
REQ-005 SHALL have port Load  input  1  single-cycle strobe (already debounced and edge-detected) accepting Din.
REQ-006 SHALL have port Clear  input  1  synchronous abort of entry sequence.
REQ-007 SHALL have port F  input  32  ALU result fed back from the downstream ALU.
REQ-008 SHALL have port ZF, OF  input  1 each  ALU zero/overflow flags fed back.
REQ-009 SHALL have port AA, BB  output  32 each  operands driven to the ALU.
REQ-010 SHALL have port ALU_OP  output  3  operation code driven to the ALU.
REQ-011 SHALL have port Valid  output  1  high while AA/BB/ALU_OP form a complete operation.
REQ-012 SHALL have port State  output  2  current FSM state encoding, for LED display.
REQ-013 SHALL have port Fq, ZFq, OFq  output  32/1/1  captured ALU result and flags.

Function
REQ-014 SHALL implement FSM states S_A=2'b00, S_B=2'b01, S_OP=2'b10, S_RUN=2'b11; State outputs the encoding.
REQ-015 SHALL keep chunk counter Idx, range 0..(32/DIN_W)-1, counting accepted Loads within S_A/S_B.
REQ-016 In S_A, on Load, SHALL shift AA <= {AA[31-DIN_W:0], Din} (MSB chunk first) and increment Idx.
REQ-017 On the Load where Idx = (32/DIN_W)-1 in S_A, SHALL shift the final chunk, wrap Idx to 0, and go to S_B.
REQ-018 S_B SHALL behave as REQ-016/017 on BB, going to S_OP on the final chunk.
REQ-019 In S_OP, on Load, SHALL set ALU_OP <= Din[2:0] and go to S_RUN; Din upper bits ignored.
REQ-020 Valid SHALL be 1 exactly while in S_RUN; it rises on the same edge that registers ALU_OP.
REQ-021 In S_RUN, Load SHALL clear AA, BB, Idx to 0, deassert Valid, go to S_A; Din is NOT consumed on that edge; ALU_OP is held.
REQ-022 Clear SHALL, in any state, zero AA, BB, ALU_OP, Idx, deassert Valid, go to S_A; Clear has priority over Load.
REQ-023 Without Load or Clear, all registers SHALL hold.
REQ-024 Capture: on the first rising edge after entering S_RUN, SHALL register Fq<=F, ZFq<=ZF, OFq<=OF (one cycle latency from Valid rise); captured values hold until the next capture, reset, or Clear.
REQ-025 A Load on the first S_RUN cycle SHALL still perform the capture on that edge and the S_A transition.
REQ-026 Clear SHALL zero Fq, ZFq, OFq.

Reset
REQ-027 RST SHALL take priority over Clear and Load.
REQ-028 On RST: State=S_A, Idx=0, AA=0, BB=0, ALU_OP=3'b000, Valid=0, Fq=0, ZFq=0, OFq=0.
REQ-029 RST asserted mid-sequence SHALL discard all partially loaded chunks.

Configuration
REQ-030 Macro LOADER_RESULT_CAPTURE_EN: when defined, REQ-024..026 capture logic SHALL be compiled in.
REQ-031 When undefined, ports Fq/ZFq/OFq SHALL remain present and be driven constant 0; F/ZF/OF unused; all other behaviour identical.

Structure
REQ-032 Shared package alu_pkg SHALL hold state encodings S_A..S_RUN, ALU_OP code constants (AND=000 .. SHL=111), and WORD_W=32.
REQ-033 No sub-module SHALL be instantiated; FSM, shifters and capture registers reside in this module.

Verification
REQ-034 DIN_W=8, RST then Loads 0x12,0x34,0x56,0x78 -> AA=0x12345678, State=S_B, Idx=0.
REQ-035 Continue Loads 0x00,0x00,0x00,0x01 then 0x04 -> BB=0x00000001, ALU_OP=3'b100, Valid=1 on that edge; with ALU model Fq=0x12345679, ZFq=0, OFq=0 one edge later.
REQ-036 AA=0x7FFFFFFF, BB=0x00000001, op 3'b100 -> Fq=0x80000000, OFq=1; then Load in S_RUN -> State=S_A, AA=BB=0, Valid=0, ALU_OP still 3'b100, Fq held.
REQ-037 Two chunks into S_B, assert Clear and Load same cycle -> State=S_A, all operands 0, Load ignored.
REQ-038 RST during S_OP -> all outputs at REQ-028 values next edge; macro undefined build -> Fq/ZFq/OFq stay 0 throughout REQ-035.
